// File: rtl/mem_arbiter.sv
// Two-requester Wishbone B4 arbiter: round-robin grant, CYC locking, ACK watchdog, write snoop.
// Latency: grant one cycle after CYC rises; ACK/data/stall pass through combinationally; snoop one cycle after ACK.
// Backpressure: non-owners see stall=1; the owner sees m_stall directly; an aborted owner is stalled until it drops CYC.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_cyc,
   input  logic        r0_stb,
   input  logic        r0_we,
   input  logic [31:0] r0_adr,
   input  logic [31:0] r0_dat_o,
   input  logic [3:0]  r0_sel,
   output logic [31:0] r0_dat_i,
   output logic        r0_ack,
   output logic        r0_err,
   output logic        r0_stall,
   input  logic        r1_cyc,
   input  logic        r1_stb,
   input  logic        r1_we,
   input  logic [31:0] r1_adr,
   input  logic [31:0] r1_dat_o,
   input  logic [3:0]  r1_sel,
   output logic [31:0] r1_dat_i,
   output logic        r1_ack,
   output logic        r1_err,
   output logic        r1_stall,
   output logic        m_cyc,
   output logic        m_stb,
   output logic        m_we,
   output logic [31:0] m_adr,
   output logic [31:0] m_dat_o,
   output logic [3:0]  m_sel,
   input  logic [31:0] m_dat_i,
   input  logic        m_ack,
   input  logic        m_stall,
   output logic        snoop_valid,
   output logic [31:0] snoop_addr,
   output logic        snoop_src
);

   // A zero timeout still needs a legal (unused) counter width.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

   state_t        state, state_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          timeout;
   logic          snoop_hit;

   // Owner-side view of the request, selected by which OWN state we are in.
   logic          own;
   logic          o_cyc, o_stb, o_we, other_cyc;
   logic [31:0]   o_adr, o_dat;
   logic [3:0]    o_sel;

   assign own       = (state == OWN1);
   assign o_cyc     = own ? r1_cyc   : r0_cyc;
   assign o_stb     = own ? r1_stb   : r0_stb;
   assign o_we      = own ? r1_we    : r0_we;
   assign o_adr     = own ? r1_adr   : r0_adr;
   assign o_dat     = own ? r1_dat_o : r0_dat_o;
   assign o_sel     = own ? r1_sel   : r0_sel;
   assign other_cyc = own ? r0_cyc   : r1_cyc;

   // State, round-robin pointer and watchdog counter; reset drops the bus immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, bus routing, handshake return and watchdog evaluation.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = '0;
      timeout   = 1'b0;
      snoop_hit = 1'b0;
      m_cyc     = 1'b0;
      m_stb     = 1'b0;
      m_we      = 1'b0;
      m_adr     = '0;
      m_dat_o   = '0;
      m_sel     = '0;
      r0_dat_i  = '0;
      r0_ack    = 1'b0;
      r0_err    = 1'b0;
      r0_stall  = 1'b1;
      r1_dat_i  = '0;
      r1_ack    = 1'b0;
      r1_err    = 1'b0;
      r1_stall  = 1'b1;
      case (state)
         IDLE: begin
            // On a tie, the requester that did not win last time gets the bus.
            if (r0_cyc && (!r1_cyc || last)) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
            end else if (r1_cyc) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            m_cyc   = o_cyc;
            m_stb   = o_stb;
            m_we    = o_we;
            m_adr   = o_adr;
            m_dat_o = o_dat;
            m_sel   = o_sel;
            // An ACK in the match cycle wins over the abort.
            timeout = (TIMEOUT_CYCLES > 0) && o_cyc && o_stb && !m_ack && (cnt == TMAX);
            if (own) begin
               r1_dat_i = m_dat_i;
               r1_ack   = m_ack;
               r1_stall = m_stall;
               r1_err   = timeout;
            end else begin
               r0_dat_i = m_dat_i;
               r0_ack   = m_ack;
               r0_stall = m_stall;
               r0_err   = timeout;
            end
            if (timeout) begin
               m_cyc = 1'b0;
               m_stb = 1'b0;
            end
            snoop_hit = o_cyc && m_ack && o_we;
            if (!o_cyc) begin
               // Release: hand straight over if the other side is waiting.
               if (other_cyc) begin
                  state_nxt = own ? OWN0 : OWN1;
                  last_nxt  = !own;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (timeout) begin
               state_nxt = ABORT;
            end else if ((TIMEOUT_CYCLES > 0) && o_stb && !m_ack) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ABORT: begin
            // Bus stays quiet; the aborted owner (last granted) must drop CYC first.
            if (!(last ? r1_cyc : r0_cyc)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered snoop broadcast of each acknowledged write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snoop_valid <= 1'b0;
         snoop_addr  <= '0;
         snoop_src   <= 1'b0;
      end else begin
         snoop_valid <= snoop_hit;
         if (snoop_hit) begin
            snoop_addr <= o_adr;
            snoop_src  <= own;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of per-cycle vectors plus timeout and async-reset sequences.
// Two instances share inputs: default watchdog (255) and a short one (4) for the abort cases.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_mem_arbiter;

   localparam logic [31:0] Z  = 32'h0;
   localparam logic [31:0] A0 = 32'h0000_0100;
   localparam logic [31:0] A1 = 32'h0000_0200;
   localparam logic [31:0] AW = 32'h2000_0040;
   localparam logic [31:0] AS = 32'h0000_0300;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r0_cyc = 0, r0_stb = 0, r0_we = 0;
   logic [31:0] r0_adr = 0, r0_dat_o = 32'h11;
   logic [3:0]  r0_sel = 4'hF;
   logic        r1_cyc = 0, r1_stb = 0, r1_we = 0;
   logic [31:0] r1_adr = 0, r1_dat_o = 32'h55;
   logic [3:0]  r1_sel = 4'hF;
   logic [31:0] m_dat_i = 0;
   logic        m_ack = 0, m_stall = 0;

   logic [31:0] r0_dat_i, r1_dat_i, m_adr, m_dat_o, snoop_addr;
   logic        r0_ack, r0_err, r0_stall, r1_ack, r1_err, r1_stall;
   logic        m_cyc, m_stb, m_we, snoop_valid, snoop_src;
   logic [3:0]  m_sel;

   logic [31:0] t_r0_dat_i, t_r1_dat_i, t_m_adr, t_m_dat_o, t_snoop_addr;
   logic        t_r0_ack, t_r0_err, t_r0_stall, t_r1_ack, t_r1_err, t_r1_stall;
   logic        t_m_cyc, t_m_stb, t_m_we, t_snoop_valid, t_snoop_src;
   logic [3:0]  t_m_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst),
      .r0_cyc(r0_cyc), .r0_stb(r0_stb), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat_o(r0_dat_o), .r0_sel(r0_sel),
      .r0_dat_i(r0_dat_i), .r0_ack(r0_ack), .r0_err(r0_err), .r0_stall(r0_stall),
      .r1_cyc(r1_cyc), .r1_stb(r1_stb), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat_o(r1_dat_o), .r1_sel(r1_sel),
      .r1_dat_i(r1_dat_i), .r1_ack(r1_ack), .r1_err(r1_err), .r1_stall(r1_stall),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o), .m_sel(m_sel),
      .m_dat_i(m_dat_i), .m_ack(m_ack), .m_stall(m_stall),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src)
   );

   mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
      .clk(clk), .rst(rst),
      .r0_cyc(r0_cyc), .r0_stb(r0_stb), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat_o(r0_dat_o), .r0_sel(r0_sel),
      .r0_dat_i(t_r0_dat_i), .r0_ack(t_r0_ack), .r0_err(t_r0_err), .r0_stall(t_r0_stall),
      .r1_cyc(r1_cyc), .r1_stb(r1_stb), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat_o(r1_dat_o), .r1_sel(r1_sel),
      .r1_dat_i(t_r1_dat_i), .r1_ack(t_r1_ack), .r1_err(t_r1_err), .r1_stall(t_r1_stall),
      .m_cyc(t_m_cyc), .m_stb(t_m_stb), .m_we(t_m_we), .m_adr(t_m_adr), .m_dat_o(t_m_dat_o), .m_sel(t_m_sel),
      .m_dat_i(m_dat_i), .m_ack(m_ack), .m_stall(m_stall),
      .snoop_valid(t_snoop_valid), .snoop_addr(t_snoop_addr), .snoop_src(t_snoop_src)
   );

   typedef struct {
      logic [5:0]  req;   // c0 s0 w0 c1 s1 w1
      logic [31:0] a0, a1;
      logic [1:0]  mem;   // m_ack m_stall
      logic [31:0] mdat;
      logic [6:0]  ex;    // m_cyc r0_ack r0_stall r1_ack r1_stall snoop_valid snoop_src
      logic [31:0] madr, dat0, dat1, sna;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] req, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [1:0] mem, input logic [31:0] mdat, input logic [6:0] ex,
                               input logic [31:0] madr, input logic [31:0] dat0, input logic [31:0] dat1,
                               input logic [31:0] sna);
      vec_t v;
      v.req = req; v.a0 = a0; v.a1 = a1; v.mem = mem; v.mdat = mdat;
      v.ex = ex; v.madr = madr; v.dat0 = dat0; v.dat1 = dat1; v.sna = sna;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      r0_cyc = 0; r0_stb = 0; r0_we = 0;
      r1_cyc = 0; r1_stb = 0; r1_we = 0;
      m_ack = 0; m_stall = 0; m_dat_i = 0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      // Tie after reset: r0 first, then handover to r1.
      tbl.push_back(mk(6'b1_1_0_1_1_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_1_1_0, A0, A1, 2'b1_0, 32'hA0,   7'b1_1_0_0_1_0_0, A0, 32'hA0,   Z,        Z));
      tbl.push_back(mk(6'b0_0_0_1_1_0, A0, A1, 2'b0_0, Z,        7'b0_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_1_1_0, A0, A1, 2'b1_0, 32'hB1,   7'b1_0_1_1_0_0_0, A1, Z,        32'hB1,   Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_0_0_0, A1, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      // Single read by r0, ack two cycles after grant.
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b1_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b1_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b1_0, DB,       7'b1_1_0_0_1_0_0, A0, DB,       Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      // Tie with r0 granted last: r1 wins, then handover back to r0.
      tbl.push_back(mk(6'b1_1_0_1_1_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_1_1_0, A0, A1, 2'b0_0, Z,        7'b1_0_1_0_0_0_0, A1, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_0_0_0, A1, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b1_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_0_0_1_0_0, A0, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      // r1 write: snoop one cycle after the ack.
      tbl.push_back(mk(6'b0_0_0_1_1_1, A0, AW, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_1_1_1, A0, AW, 2'b0_0, Z,        7'b1_0_1_0_0_0_0, AW, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_1_1_1, A0, AW, 2'b1_0, Z,        7'b1_0_1_1_0_0_0, AW, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, AW, 2'b0_0, Z,        7'b0_0_1_0_0_1_1, AW, Z,        Z,        AW));
      tbl.push_back(mk(6'b0_0_0_0_0_0, A0, AW, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      // r0 write with three stall cycles.
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b0_1, Z,        7'b1_0_1_0_1_0_0, AS, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b0_1, Z,        7'b1_0_1_0_1_0_0, AS, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b0_1, Z,        7'b1_0_1_0_1_0_0, AS, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b0_0, Z,        7'b1_0_0_0_1_0_0, AS, Z,        Z,        Z));
      tbl.push_back(mk(6'b1_1_1_0_0_0, AS, A1, 2'b1_0, Z,        7'b1_1_0_0_1_0_0, AS, Z,        Z,        Z));
      tbl.push_back(mk(6'b0_0_0_0_0_0, AS, A1, 2'b0_0, Z,        7'b0_0_0_0_1_1_0, AS, Z,        Z,        AS));
      tbl.push_back(mk(6'b0_0_0_0_0_0, AS, A1, 2'b0_0, Z,        7'b0_0_1_0_1_0_0, Z,  Z,        Z,        Z));

      // Reset values while reset is held.
      idle_inputs();
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_mcyc",   m_cyc, 0);
      chk("rst_mstb",   m_stb, 0);
      chk("rst_r0stall", r0_stall, 1);
      chk("rst_r1stall", r1_stall, 1);
      chk("rst_acks",   {r0_ack, r1_ack, r0_err, r1_err}, 0);
      chk("rst_snoop",  {snoop_valid, snoop_src}, 0);
      chk("rst_snaddr", snoop_addr, 0);
      #1 rst = 1'b0;

      // Table vectors against the 255-cycle instance.
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         {r0_cyc, r0_stb, r0_we, r1_cyc, r1_stb, r1_we} = tbl[i].req;
         r0_adr = tbl[i].a0;
         r1_adr = tbl[i].a1;
         {m_ack, m_stall} = tbl[i].mem;
         m_dat_i = tbl[i].mdat;
         @(negedge clk);
         chk($sformatf("row%0d_mcyc", i),   m_cyc,       tbl[i].ex[6]);
         chk($sformatf("row%0d_madr", i),   m_adr,       tbl[i].madr);
         chk($sformatf("row%0d_r0ack", i),  r0_ack,      tbl[i].ex[5]);
         chk($sformatf("row%0d_r0stall", i), r0_stall,   tbl[i].ex[4]);
         chk($sformatf("row%0d_r1ack", i),  r1_ack,      tbl[i].ex[3]);
         chk($sformatf("row%0d_r1stall", i), r1_stall,   tbl[i].ex[2]);
         chk($sformatf("row%0d_r0dat", i),  r0_dat_i,    tbl[i].dat0);
         chk($sformatf("row%0d_r1dat", i),  r1_dat_i,    tbl[i].dat1);
         chk($sformatf("row%0d_err", i),    {r0_err, r1_err}, 0);
         chk($sformatf("row%0d_snv", i),    snoop_valid, tbl[i].ex[1]);
         if (tbl[i].ex[1]) begin
            chk($sformatf("row%0d_sna", i), snoop_addr, tbl[i].sna);
            chk($sformatf("row%0d_src", i), snoop_src,  tbl[i].ex[0]);
         end
      end

      // Watchdog on the 4-cycle instance: ack wins the first match, second match aborts.
      pulse_reset();
      for (int k = 0; k <= 15; k++) begin
         @(posedge clk); #1;
         r0_cyc = (k <= 12); r0_stb = (k <= 12); r0_we = 0; r0_adr = A0;
         r1_cyc = (k >= 7);  r1_stb = (k >= 7);  r1_we = 0; r1_adr = A1;
         m_ack = (k == 5); m_stall = 0; m_dat_i = 0;
         @(negedge clk);
         chk($sformatf("to%0d_err", k),  t_r0_err, (k == 10));
         chk($sformatf("to%0d_mcyc", k), t_m_cyc, ((k >= 1 && k <= 9) || k == 15));
         if (k == 5)  chk("to_ack_priority", t_r0_ack, 1);
         if (k >= 10 && k <= 14) chk($sformatf("to%0d_mstb", k), t_m_stb, 0);
         if (k >= 11 && k <= 13) begin
            chk($sformatf("to%0d_abort_stall", k), t_r0_stall, 1);
            chk($sformatf("to%0d_abort_ack", k), t_r0_ack, 0);
         end
         if (k == 15) begin
            chk("to_r1_grant_adr", t_m_adr, A1);
            chk("to_r1_stall", t_r1_stall, 0);
         end
      end

      // Asynchronous reset while r1 owns the bus with STB high.
      pulse_reset();
      @(posedge clk); #1;
      r1_cyc = 1; r1_stb = 1; r1_we = 1; r1_adr = A1;
      @(posedge clk); #1;
      chk("mid_owned", {m_cyc, m_stb}, 2'b11);
      #1 rst = 1'b1;
      #1;
      chk("mid_async_drop", {m_cyc, m_stb}, 2'b00);
      chk("mid_r1stall", r1_stall, 1);
      @(negedge clk); #1;
      rst = 1'b0;
      r0_cyc = 1; r0_stb = 1; r0_we = 0; r0_adr = A0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_tie_mcyc", m_cyc, 1);
      chk("post_rst_tie_adr", m_adr, A0);
      chk("post_rst_tie_r1stall", r1_stall, 1);
      chk("post_rst_snoop", snoop_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
